pipeline_hazard_ctrl: RTL

- Pipeline sequencing controller for the 5-stage RV32I core.
- Generates per-stage stall, flush and bubble controls for load-use hazards, taken-branch redirects and data-memory wait states.
- Tracks memory wait cycles with a timeout watchdog.
- Sits beside the EX-stage forwarding unit and covers the hazards that forwarding cannot resolve.

---
 rtl/pipeline_hazard_ctrl.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing controller: stall/flush/bubble generation for load-use, branch redirect and
// data-memory waits, with a wait watchdog. Optional perf counters under `HAZARD_PERF_CNT_EN`.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 256,
  parameter int TO_CNT_W    = 9
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [4:0]  i_id_rs1,
  input  logic [4:0]  i_id_rs2,
  input  logic        i_id_uses_rs1,
  input  logic        i_id_uses_rs2,
  input  logic [4:0]  i_ex_rd,
  input  logic        i_ex_mem_read,
  input  logic        i_ex_branch_taken,
  input  logic        i_mem_req,
  input  logic        i_mem_ready,
  output logic        o_stall_pc,
  output logic        o_stall_if_id,
  output logic        o_stall_id_ex,
  output logic        o_stall_ex_mem,
  output logic        o_flush_if_id,
  output logic        o_flush_id_ex,
  output logic        o_bubble_mem_wb,
  output logic        o_redirect_en,
  output logic        o_mem_timeout,
  output logic        o_halted
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] o_perf_lu_stalls,
  output logic [31:0] o_perf_mem_stall_cycles,
  output logic [31:0] o_perf_flushes
`endif
);

  localparam logic [1:0] S_RUN  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  localparam bit                  TO_EN   = (MEM_TIMEOUT != 0);
  localparam logic [TO_CNT_W-1:0] TO_VAL  = TO_CNT_W'(MEM_TIMEOUT);
  localparam logic [TO_CNT_W-1:0] CNT_ONE = TO_CNT_W'(1);

  logic [1:0]          r_state;
  logic [1:0]          w_state_next;
  logic [TO_CNT_W-1:0] r_cnt;
  logic [TO_CNT_W-1:0] w_cnt_next;
  logic [TO_CNT_W-1:0] w_cnt_inc;
  logic                r_timeout;
  logic                w_set_timeout;
  logic                w_mem_stall;
  logic                w_lu_hazard;
  logic                w_active;
  logic                w_do_branch;
  logic                w_do_lu;

  assign w_mem_stall = i_mem_req & ~i_mem_ready;
  assign w_lu_hazard = i_ex_mem_read & (i_ex_rd != 5'd0) &
                       ((i_id_uses_rs1 & (i_id_rs1 == i_ex_rd)) |
                        (i_id_uses_rs2 & (i_id_rs2 == i_ex_rd)));

  assign w_active    = (r_state != S_HALT);
  assign w_do_branch = w_active & ~w_mem_stall & i_ex_branch_taken;
  assign w_do_lu     = w_active & ~w_mem_stall & ~i_ex_branch_taken & w_lu_hazard;

  assign w_cnt_inc = (r_cnt == {TO_CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_ONE;

  // The count after this cycle equals the number of consecutive stalled cycles seen so far.
  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_set_timeout = 1'b0;
    case (r_state)
      S_RUN: begin
        if (w_mem_stall) begin
          w_cnt_next = CNT_ONE;
          if (TO_EN && (TO_VAL == CNT_ONE)) begin
            w_state_next  = S_HALT;
            w_set_timeout = 1'b1;
          end else begin
            w_state_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (w_mem_stall) begin
          w_cnt_next = w_cnt_inc;
          if (TO_EN && (w_cnt_inc == TO_VAL)) begin
            w_state_next  = S_HALT;
            w_set_timeout = 1'b1;
          end
        end else begin
          w_state_next = S_RUN;
          w_cnt_next   = '0;
        end
      end
      S_HALT: begin
        w_state_next = S_HALT;
      end
      default: begin
        w_state_next = S_RUN;
        w_cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_RUN;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_set_timeout) begin
        r_timeout <= 1'b1;
      end
    end
  end

  // Outputs follow the inputs with no latency; reset forces them low even while inputs are active.
  always_comb begin
    o_stall_pc      = 1'b0;
    o_stall_if_id   = 1'b0;
    o_stall_id_ex   = 1'b0;
    o_stall_ex_mem  = 1'b0;
    o_flush_if_id   = 1'b0;
    o_flush_id_ex   = 1'b0;
    o_bubble_mem_wb = 1'b0;
    o_redirect_en   = 1'b0;
    o_mem_timeout   = 1'b0;
    o_halted        = 1'b0;
    if (i_rst_n) begin
      o_mem_timeout = r_timeout;
      if (!w_active || w_mem_stall) begin
        o_stall_pc      = 1'b1;
        o_stall_if_id   = 1'b1;
        o_stall_id_ex   = 1'b1;
        o_stall_ex_mem  = 1'b1;
        o_bubble_mem_wb = 1'b1;
        o_halted        = !w_active;
      end else if (w_do_branch) begin
        o_redirect_en = 1'b1;
        o_flush_if_id = 1'b1;
        o_flush_id_ex = 1'b1;
      end else if (w_do_lu) begin
        o_stall_pc    = 1'b1;
        o_stall_if_id = 1'b1;
        o_flush_id_ex = 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_perf_lu;
  logic [31:0] r_perf_mem;
  logic [31:0] r_perf_flush;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_perf_lu    <= '0;
      r_perf_mem   <= '0;
      r_perf_flush <= '0;
    end else begin
      if (w_do_lu) begin
        r_perf_lu <= r_perf_lu + 32'd1;
      end
      if (w_active && w_mem_stall) begin
        r_perf_mem <= r_perf_mem + 32'd1;
      end
      if (w_do_branch) begin
        r_perf_flush <= r_perf_flush + 32'd1;
      end
    end
  end

  assign o_perf_lu_stalls        = r_perf_lu;
  assign o_perf_mem_stall_cycles = r_perf_mem;
  assign o_perf_flushes          = r_perf_flush;
`endif

endmodule
